// File: rtl/conv_window_addr_seq.sv
// Sliding KSIZE x KSIZE window address sequencer over an IMG_W x IMG_W input matrix.
// Define CONV_SEQ_STALL_CNT_EN to add the stall_cnt port and its saturating counter.
module conv_window_addr_seq #(
    parameter int IMG_W  = 32,
    parameter int KSIZE  = 4,
    parameter int STRIDE = 1,
    parameter int ADDR_W = 10
`ifdef CONV_SEQ_STALL_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              abort,
    output logic                              busy,
    output logic                              done,
    output logic                              addr_valid,
    input  logic                              addr_ready,
    output logic [ADDR_W-1:0]                 ram_addr,
    output logic [$clog2(KSIZE*KSIZE)-1:0]    coef_addr,
    output logic                              win_first,
    output logic                              win_last,
`ifdef CONV_SEQ_STALL_CNT_EN
    output logic [CNT_W-1:0]                  stall_cnt,
`endif
    output logic                              frame_last
);

    localparam int OUT_DIM = (IMG_W - KSIZE) / STRIDE + 1;
    localparam int CW      = $clog2(KSIZE * KSIZE);
    localparam int KW      = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam int OW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int AW1     = ADDR_W + 1;

    localparam logic [AW1-1:0] ROW_STEP  = AW1'(IMG_W);
    localparam logic [AW1-1:0] COL_STEP  = AW1'(STRIDE);
    localparam logic [AW1-1:0] WROW_STEP = AW1'(STRIDE * IMG_W);
    localparam logic [KW-1:0]  K_LAST    = KW'(KSIZE - 1);
    localparam logic [OW-1:0]  O_LAST    = OW'(OUT_DIM - 1);
    localparam logic [CW-1:0]  C_LAST    = CW'(KSIZE * KSIZE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e state_q, state_d;

    logic [KW-1:0]  kc_q, kc_d, kr_q, kr_d;
    logic [OW-1:0]  oc_q, oc_d, orow_q, orow_d;
    logic [AW1-1:0] addr_q, addr_d;
    logic [AW1-1:0] rowBase_q, rowBase_d;
    logic [AW1-1:0] winBase_q, winBase_d;
    logic [AW1-1:0] winRowBase_q, winRowBase_d;
    logic [CW-1:0]  coef_q, coef_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           first_q, first_d;
    logic           last_q, last_d;
    logic           frameLast_q, frameLast_d;
    logic           handshake;

    assign handshake = valid_q && addr_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start && !abort) state_d = RUN;
            RUN: begin
                if (abort)                         state_d = IDLE;
                else if (handshake && frameLast_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address walks incrementally: window-row base -> window base -> kernel-row base -> tap.
    always_comb begin
        kc_d         = kc_q;
        kr_d         = kr_q;
        oc_d         = oc_q;
        orow_d       = orow_q;
        addr_d       = addr_q;
        rowBase_d    = rowBase_q;
        winBase_d    = winBase_q;
        winRowBase_d = winRowBase_q;
        coef_d       = coef_q;
        valid_d      = valid_q;
        first_d      = first_q;
        last_d       = last_q;
        frameLast_d  = frameLast_q;
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);

        if (state_q == IDLE && state_d == RUN) begin
            kc_d         = '0;
            kr_d         = '0;
            oc_d         = '0;
            orow_d       = '0;
            addr_d       = '0;
            rowBase_d    = '0;
            winBase_d    = '0;
            winRowBase_d = '0;
            coef_d       = '0;
            valid_d      = 1'b1;
            first_d      = 1'b1;
            last_d       = (C_LAST == '0);
            frameLast_d  = (C_LAST == '0) && (OUT_DIM == 1);
        end else if (state_q == RUN && state_d == IDLE) begin
            valid_d     = 1'b0;
            first_d     = 1'b0;
            last_d      = 1'b0;
            frameLast_d = 1'b0;
        end else if (state_q == RUN && handshake) begin
            if (state_d == DONE) begin
                kc_d         = '0;
                kr_d         = '0;
                oc_d         = '0;
                orow_d       = '0;
                addr_d       = '0;
                rowBase_d    = '0;
                winBase_d    = '0;
                winRowBase_d = '0;
                coef_d       = '0;
                valid_d      = 1'b0;
                first_d      = 1'b0;
                last_d       = 1'b0;
                frameLast_d  = 1'b0;
            end else begin
                coef_d = (coef_q == C_LAST) ? '0 : coef_q + 1'b1;
                if (kc_q != K_LAST) begin
                    kc_d   = kc_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                end else begin
                    kc_d = '0;
                    if (kr_q != K_LAST) begin
                        kr_d      = kr_q + 1'b1;
                        rowBase_d = rowBase_q + ROW_STEP;
                    end else begin
                        kr_d = '0;
                        if (oc_q != O_LAST) begin
                            oc_d      = oc_q + 1'b1;
                            winBase_d = winBase_q + COL_STEP;
                        end else begin
                            oc_d         = '0;
                            orow_d       = orow_q + 1'b1;
                            winRowBase_d = winRowBase_q + WROW_STEP;
                            winBase_d    = winRowBase_d;
                        end
                        rowBase_d = winBase_d;
                    end
                    addr_d = rowBase_d;
                end
                first_d     = (coef_d == '0);
                last_d      = (coef_d == C_LAST);
                frameLast_d = last_d && (oc_d == O_LAST) && (orow_d == O_LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kc_q         <= '0;
            kr_q         <= '0;
            oc_q         <= '0;
            orow_q       <= '0;
            addr_q       <= '0;
            rowBase_q    <= '0;
            winBase_q    <= '0;
            winRowBase_q <= '0;
            coef_q       <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            frameLast_q  <= 1'b0;
        end else begin
            kc_q         <= kc_d;
            kr_q         <= kr_d;
            oc_q         <= oc_d;
            orow_q       <= orow_d;
            addr_q       <= addr_d;
            rowBase_q    <= rowBase_d;
            winBase_q    <= winBase_d;
            winRowBase_q <= winRowBase_d;
            coef_q       <= coef_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            first_q      <= first_d;
            last_q       <= last_d;
            frameLast_q  <= frameLast_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign addr_valid = valid_q;
    assign ram_addr   = addr_q[ADDR_W-1:0];
    assign coef_addr  = coef_q;
    assign win_first  = first_q;
    assign win_last   = last_q;
    assign frame_last = frameLast_q;

`ifdef CONV_SEQ_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && state_d == RUN)
            stall_d = '0;
        else if (state_q == RUN && valid_q && !addr_ready && stall_q != '1)
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_conv_window_addr_seq.sv
// Self-checking bench for conv_window_addr_seq: default 32/4/1 instance plus an 8/4/2 instance.
// Stall counter checks are compiled in when CONV_SEQ_STALL_CNT_EN is defined.
module tb_conv_window_addr_seq;

    localparam int TOTAL1 = 29 * 29 * 16;
    localparam int TOTAL2 = 3 * 3 * 16;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start, abort, addrReady;
    logic        busy, done, addrValid, winFirst, winLast, frameLast;
    logic [9:0]  ramAddr;
    logic [3:0]  coefAddr;

    logic        start2, abort2, addrReady2;
    logic        busy2, done2, addrValid2, winFirst2, winLast2, frameLast2;
    logic [5:0]  ramAddr2;
    logic [3:0]  coefAddr2;
`ifdef CONV_SEQ_STALL_CNT_EN
    logic [15:0] stallCnt, stallCnt2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_window_addr_seq dut (
        .clk(clk), .reset(rstN), .start(start), .abort(abort),
        .busy(busy), .done(done), .addr_valid(addrValid), .addr_ready(addrReady),
        .ram_addr(ramAddr), .coef_addr(coefAddr),
        .win_first(winFirst), .win_last(winLast),
`ifdef CONV_SEQ_STALL_CNT_EN
        .stall_cnt(stallCnt),
`endif
        .frame_last(frameLast)
    );

    conv_window_addr_seq #(.IMG_W(8), .KSIZE(4), .STRIDE(2), .ADDR_W(6)) dut2 (
        .clk(clk), .reset(rstN), .start(start2), .abort(abort2),
        .busy(busy2), .done(done2), .addr_valid(addrValid2), .addr_ready(addrReady2),
        .ram_addr(ramAddr2), .coef_addr(coefAddr2),
        .win_first(winFirst2), .win_last(winLast2),
`ifdef CONV_SEQ_STALL_CNT_EN
        .stall_cnt(stallCnt2),
`endif
        .frame_last(frameLast2)
    );

    function automatic logic [31:0] packTap(logic v, logic [15:0] a, logic [7:0] c,
                                            logic f, logic l, logic fl);
        return {4'b0, v, a, c, f, l, fl};
    endfunction

    // Reference tap: decompose the flat handshake index into window/tap coordinates.
    function automatic logic [31:0] modelTap(int idx, int w, int k, int s, int total);
        int od, tap, win, kr, kc, oc, orow, addr;
        od   = (w - k) / s + 1;
        tap  = idx % (k * k);
        win  = idx / (k * k);
        kr   = tap / k;
        kc   = tap % k;
        oc   = win % od;
        orow = win / od;
        addr = (orow * s + kr) * w + oc * s + kc;
        return packTap(1'b1, 16'(addr), 8'(tap), tap == 0, tap == k * k - 1, idx == total - 1);
    endfunction

    function automatic logic [31:0] obsTap();
        return packTap(addrValid, 16'(ramAddr), 8'(coefAddr), winFirst, winLast, frameLast);
    endfunction

    function automatic logic [31:0] obsCtl();
        return 32'({busy, done, addrValid, winFirst, winLast, frameLast, ramAddr, coefAddr});
    endfunction

    function automatic logic [31:0] obsCtl2();
        return 32'({busy2, done2, addrValid2, winFirst2, winLast2, frameLast2, ramAddr2, coefAddr2});
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic r);
        start     = s;
        abort     = a;
        addrReady = r;
        @(negedge clk);
    endtask

    // Streams taps of the default instance, checking every cycle so stalls prove outputs frozen.
    task automatic streamTaps(input int nTaps, input int readyPct, input int startAt,
                              input int abortAt, output int taken);
        int idx;
        int cyc;
        bit aborted;
        idx = 0;
        cyc = 0;
        aborted = 1'b0;
        while (idx < nTaps && cyc < 4 * nTaps + 100 && !aborted) begin
            checkOutput("tap", obsTap(), modelTap(idx, 32, 4, 1, TOTAL1));
            start = (idx == startAt);
            if (idx == abortAt) begin
                abort     = 1'b1;
                addrReady = 1'b1;
                aborted   = 1'b1;
            end else begin
                addrReady = ($urandom_range(99) < readyPct);
                if (addrReady) idx++;
            end
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            cyc++;
        end
        if (!aborted && idx < nTaps) checkOutput("stream_timeout", 32'(idx), 32'(nTaps));
        taken = idx;
    endtask

    task automatic checkDone(input string tag);
        checkOutput({tag, "_done"}, 32'({done, busy, addrValid}), 32'(3'b110));
        addrReady = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_idle"}, 32'({done, busy, addrValid}), 32'(3'b000));
    endtask

    initial begin
        int n;
        int s1Addr[17] = '{0, 1, 2, 3, 32, 33, 34, 35, 64, 65, 66, 67, 96, 97, 98, 99, 1};
        int bases[9]   = '{0, 2, 4, 16, 18, 20, 32, 34, 36};
        int idx2;
        int cyc2;

        rstN = 1'b0; start = 1'b0; abort = 1'b0; addrReady = 1'b0;
        start2 = 1'b0; abort2 = 1'b0; addrReady2 = 1'b0;
        #2;
        checkOutput("reset_outputs", obsCtl(), 32'd0);
        checkOutput("reset_outputs2", obsCtl2(), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("idle_after_reset", obsCtl(), 32'd0);

        // Scenario 1: first window taps and start of second window.
        applyStimulus(1'b1, 1'b0, 1'b0);
        start = 1'b0;
        addrReady = 1'b1;
        for (int i = 0; i < 17; i++) begin
            checkOutput("s1_addr", 32'(ramAddr), 32'(s1Addr[i]));
            checkOutput("s1_coef", 32'(coefAddr), 32'(i % 16));
            checkOutput("s1_flags", 32'({winFirst, winLast}), 32'({(i % 16) == 0, (i % 16) == 15}));
            @(negedge clk);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        abort = 1'b0;
        checkOutput("s1_abort", obsCtl() & 32'hFC000, 32'd0);

        // Scenario 2: full-throughput frame.
        applyStimulus(1'b1, 1'b0, 1'b0);
        start = 1'b0;
        streamTaps(TOTAL1, 100, -1, -1, n);
        checkDone("s2");

        // Scenario 3: random backpressure, same handshake sequence.
        applyStimulus(1'b1, 1'b0, 1'b0);
        start = 1'b0;
        streamTaps(TOTAL1, 50, -1, -1, n);
        checkDone("s3");

        // Scenario 4: abort at handshake 500, then restart.
        applyStimulus(1'b1, 1'b0, 1'b0);
        start = 1'b0;
        streamTaps(501, 100, -1, 500, n);
        addrReady = 1'b0;
        checkOutput("s4_abort", 32'({done, busy, addrValid, winFirst, winLast, frameLast}), 32'd0);
        @(negedge clk);
        checkOutput("s4_no_done", 32'({done, busy, addrValid}), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        start = 1'b0;
        checkOutput("s4_restart", obsTap(), modelTap(0, 32, 4, 1, TOTAL1));
        applyStimulus(1'b0, 1'b1, 1'b0);
        abort = 1'b0;

        // Scenario 5: start while busy, then asynchronous reset mid-frame.
        applyStimulus(1'b1, 1'b0, 1'b0);
        start = 1'b0;
        streamTaps(20, 100, 10, -1, n);
        addrReady = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("s5_async_reset", obsCtl(), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("s5_idle", obsCtl(), 32'd0);

        // Scenario 6: strided instance with an initial 7-cycle stall.
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        idx2 = 0;
        cyc2 = 0;
        while (idx2 < TOTAL2 && cyc2 < 400) begin
            checkOutput("s6_tap",
                        packTap(addrValid2, 16'(ramAddr2), 8'(coefAddr2), winFirst2, winLast2, frameLast2),
                        modelTap(idx2, 8, 4, 2, TOTAL2));
            if (idx2 % 16 == 0) checkOutput("s6_base", 32'(ramAddr2), 32'(bases[idx2 / 16]));
            if (idx2 == TOTAL2 - 1) checkOutput("s6_last_addr", 32'(ramAddr2), 32'd63);
            addrReady2 = (cyc2 >= 7);
            if (addrReady2) idx2++;
            @(negedge clk);
            cyc2++;
        end
        if (idx2 < TOTAL2) checkOutput("s6_timeout", 32'(idx2), 32'(TOTAL2));
        addrReady2 = 1'b0;
        checkOutput("s6_done", 32'({done2, busy2, addrValid2}), 32'(3'b110));
`ifdef CONV_SEQ_STALL_CNT_EN
        checkOutput("s6_stall_at_done", 32'(stallCnt2), 32'd7);
`endif
        @(negedge clk);
        checkOutput("s6_idle", 32'({done2, busy2, addrValid2}), 32'd0);
`ifdef CONV_SEQ_STALL_CNT_EN
        checkOutput("s6_stall_hold", 32'(stallCnt2), 32'd7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
